// File: rtl/mem_access_stage_if.sv
// Byte-wide RAM port shared between the MEM stage and the IF/MEM arbiter.
// The master side is the stage; the slave side is the arbiter plus RAM.
interface mem_access_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  mem_req_out;
    logic [ADDR_WIDTH-1:0] mem_a_out;
    logic [7:0]            mem_dout_out;
    logic                  mem_wr_out;
    logic                  mem_grant_in;
    logic [7:0]            mem_din_in;

    modport master (
        output mem_req_out, mem_a_out, mem_dout_out, mem_wr_out,
        input  mem_grant_in, mem_din_in
    );

    modport slave (
        input  mem_req_out, mem_a_out, mem_dout_out, mem_wr_out,
        output mem_grant_in, mem_din_in
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: byte-serial loads/stores over an arbitrated 8-bit RAM port.
// Optional macro IO_FULL_STALL_EN holds IO-region stores while the UART buffer is full.
module mem_access_stage #(
    parameter int unsigned          ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(32'h0003_0000)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [4:0]            rsd_addr_in,
    input  logic [31:0]           rsd_data_in,
    input  logic                  write_rsd_or_not_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic                  mem_read_or_not_in,
    input  logic                  mem_write_or_not_in,
    input  logic [2:0]            mem_op_in,
    input  logic [31:0]           store_data_in,
    input  logic                  io_buffer_full_in,
    mem_access_stage_if.master    mem,
    output logic                  stall_req_out,
    output logic [4:0]            rsd_addr_out,
    output logic [31:0]           rsd_data_out,
    output logic                  write_rsd_or_not_out
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GRANT = 2'd1,
        ACCESS     = 2'd2,
        WAIT_LAST  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            op_q, op_d;
    logic [31:0]           store_q, store_d;
    logic [4:0]            rd_q, rd_d;
    logic                  wen_q, wen_d;
    logic                  load_q, load_d;
    logic [31:0]           buf_q, buf_d;
    logic [4:0]            rsd_addr_d;
    logic [31:0]           rsd_data_d;
    logic                  wen_out_d;

    logic                  req_c;
    logic [ADDR_WIDTH-1:0] a_c;
    logic [7:0]            dout_c;
    logic                  wr_c;
    logic [1:0]            last_k_c;
    logic                  io_block_c;
    logic [31:0]           load_val_c;

    // Only stores into the IO region are throttled by the UART buffer.
`ifdef IO_FULL_STALL_EN
    assign io_block_c = !load_q && (addr_q >= IO_ADDR_BASE) && io_buffer_full_in;
`else
    logic io_unused;
    assign io_block_c = 1'b0;
    assign io_unused  = io_buffer_full_in & (addr_q >= IO_ADDR_BASE);
`endif

    assign last_k_c = (op_q[1:0] == 2'b00) ? 2'd0 :
                      (op_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

    // Sign/zero extension of the assembled load word.
    always_comb begin
        load_val_c = buf_d;
        case (op_q)
            3'b000:  load_val_c = {{24{buf_d[7]}},  buf_d[7:0]};
            3'b001:  load_val_c = {{16{buf_d[15]}}, buf_d[15:0]};
            3'b100:  load_val_c = {24'h0, buf_d[7:0]};
            3'b101:  load_val_c = {16'h0, buf_d[15:0]};
            default: load_val_c = buf_d;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        addr_d        = addr_q;
        op_d          = op_q;
        store_d       = store_q;
        rd_d          = rd_q;
        wen_d         = wen_q;
        load_d        = load_q;
        buf_d         = buf_q;
        rsd_addr_d    = rsd_addr_out;
        rsd_data_d    = rsd_data_out;
        wen_out_d     = write_rsd_or_not_out;
        stall_req_out = 1'b0;
        req_c         = 1'b0;
        a_c           = '0;
        dout_c        = 8'h00;
        wr_c          = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read_or_not_in || mem_write_or_not_in) begin
                    stall_req_out = 1'b1;
                    addr_d        = mem_addr_in;
                    op_d          = mem_op_in;
                    store_d       = store_data_in;
                    rd_d          = rsd_addr_in;
                    wen_d         = write_rsd_or_not_in;
                    load_d        = mem_read_or_not_in;
                    wen_out_d     = 1'b0;
                    state_d       = WAIT_GRANT;
                end else begin
                    rsd_addr_d = rsd_addr_in;
                    rsd_data_d = rsd_data_in;
                    wen_out_d  = write_rsd_or_not_in;
                end
            end

            WAIT_GRANT: begin
                stall_req_out = 1'b1;
                req_c         = !io_block_c;
                if (mem.mem_grant_in && !io_block_c) begin
                    state_d = ACCESS;
                    k_d     = 2'd0;
                end
            end

            ACCESS: begin
                req_c = 1'b1;
                a_c   = addr_q + ADDR_WIDTH'(k_q);
                k_d   = k_q + 2'd1;
                if (load_q) begin
                    stall_req_out = 1'b1;
                    // RAM returns a byte one cycle after its address.
                    if (k_q != 2'd0)
                        buf_d[{k_q - 2'd1, 3'b000} +: 8] = mem.mem_din_in;
                    if (k_q == last_k_c)
                        state_d = WAIT_LAST;
                end else begin
                    wr_c   = 1'b1;
                    dout_c = store_q[{k_q, 3'b000} +: 8];
                    if (k_q == last_k_c) begin
                        rsd_addr_d = rd_q;
                        rsd_data_d = 32'h0;
                        wen_out_d  = 1'b0;
                        k_d        = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        stall_req_out = 1'b1;
                    end
                end
            end

            WAIT_LAST: begin
                req_c = 1'b1;
                buf_d[{last_k_c, 3'b000} +: 8] = mem.mem_din_in;
                rsd_addr_d = rd_q;
                rsd_data_d = load_val_c;
                wen_out_d  = wen_q;
                k_d        = 2'd0;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_req_out  = req_c;
    assign mem.mem_a_out    = a_c;
    assign mem.mem_dout_out = dout_c;
    assign mem.mem_wr_out   = wr_c;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q              <= IDLE;
            k_q                  <= 2'd0;
            addr_q               <= '0;
            op_q                 <= 3'd0;
            store_q              <= 32'h0;
            rd_q                 <= 5'd0;
            wen_q                <= 1'b0;
            load_q               <= 1'b0;
            buf_q                <= 32'h0;
            rsd_addr_out         <= 5'd0;
            rsd_data_out         <= 32'h0;
            write_rsd_or_not_out <= 1'b0;
        end else begin
            state_q              <= state_d;
            k_q                  <= k_d;
            addr_q               <= addr_d;
            op_q                 <= op_d;
            store_q              <= store_d;
            rd_q                 <= rd_d;
            wen_q                <= wen_d;
            load_q               <= load_d;
            buf_q                <= buf_d;
            rsd_addr_out         <= rsd_addr_d;
            rsd_data_out         <= rsd_data_d;
            write_rsd_or_not_out <= wen_out_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: byte RAM model, writeback queue, bus traces.
module tb_mem_access_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
    } wb_t;

    logic        clk;
    logic        rst_in;
    logic [4:0]  rsd_addr_in;
    logic [31:0] rsd_data_in;
    logic        write_rsd_or_not_in;
    logic [31:0] mem_addr_in;
    logic        mem_read_or_not_in;
    logic        mem_write_or_not_in;
    logic [2:0]  mem_op_in;
    logic [31:0] store_data_in;
    logic        io_buffer_full_in;
    logic        stall_req_out;
    logic [4:0]  rsd_addr_out;
    logic [31:0] rsd_data_out;
    logic        write_rsd_or_not_out;
    logic        grant_en;
    logic        v_in;

    int n_checks = 0;
    int n_fail   = 0;

    wb_t         sb[$];
    bit          pend = 1'b0;
    logic [7:0]  ram[int unsigned];
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    logic        tr_stall[$];
    logic        tr_req[$];
    logic        tr_wr[$];
    logic [31:0] tr_a[$];

    mem_access_stage_if #(.ADDR_WIDTH(32)) mem_bus();

    mem_access_stage #(.ADDR_WIDTH(32)) dut (
        .clk_in               (clk),
        .rst_in               (rst_in),
        .rsd_addr_in          (rsd_addr_in),
        .rsd_data_in          (rsd_data_in),
        .write_rsd_or_not_in  (write_rsd_or_not_in),
        .mem_addr_in          (mem_addr_in),
        .mem_read_or_not_in   (mem_read_or_not_in),
        .mem_write_or_not_in  (mem_write_or_not_in),
        .mem_op_in            (mem_op_in),
        .store_data_in        (store_data_in),
        .io_buffer_full_in    (io_buffer_full_in),
        .mem                  (mem_bus),
        .stall_req_out        (stall_req_out),
        .rsd_addr_out         (rsd_addr_out),
        .rsd_data_out         (rsd_data_out),
        .write_rsd_or_not_out (write_rsd_or_not_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_bus.mem_grant_in = grant_en;

    // Byte RAM: synchronous read (data next cycle), write on granted write cycles.
    always @(posedge clk) begin
        if (mem_bus.mem_req_out && mem_bus.mem_grant_in) begin
            if (mem_bus.mem_wr_out) begin
                ram[mem_bus.mem_a_out] = mem_bus.mem_dout_out;
                wa.push_back(mem_bus.mem_a_out);
                wd.push_back(mem_bus.mem_dout_out);
            end else begin
                mem_bus.mem_din_in <= ram.exists(mem_bus.mem_a_out) ? ram[mem_bus.mem_a_out] : 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // An instruction leaves the stage on an edge where it is presented and stall is low.
    always @(negedge clk) begin
        wb_t e;
        if (pend) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wb_rd",   32'(rsd_addr_out),         32'(e.rd));
                check("wb_data", rsd_data_out,              e.data);
                check("wb_en",   32'(write_rsd_or_not_out), 32'(e.wen));
            end
        end
        pend = v_in && !stall_req_out && !rst_in;
    end

    task automatic clear_inputs();
        rsd_addr_in         = 5'd0;
        rsd_data_in         = 32'h0;
        write_rsd_or_not_in = 1'b0;
        mem_addr_in         = 32'h0;
        mem_read_or_not_in  = 1'b0;
        mem_write_or_not_in = 1'b0;
        mem_op_in           = 3'd0;
        store_data_in       = 32'h0;
        v_in                = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] data, input logic wen,
                         input logic rd_en, input logic wr_en, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] sdata, input wb_t exp);
        int cnt;
        tr_stall.delete(); tr_req.delete(); tr_wr.delete(); tr_a.delete();
        @(posedge clk); #1;
        rsd_addr_in         = rd;
        rsd_data_in         = data;
        write_rsd_or_not_in = wen;
        mem_read_or_not_in  = rd_en;
        mem_write_or_not_in = wr_en;
        mem_op_in           = op;
        mem_addr_in         = addr;
        store_data_in       = sdata;
        v_in                = 1'b1;
        sb.push_back(exp);
        cnt = 0;
        do begin
            @(negedge clk);
            tr_stall.push_back(stall_req_out);
            tr_req.push_back(mem_bus.mem_req_out);
            tr_wr.push_back(mem_bus.mem_wr_out);
            tr_a.push_back(mem_bus.mem_a_out);
            cnt++;
        end while (stall_req_out && cnt < 60);
        if (stall_req_out) check("issue_timeout", 32'(stall_req_out), 32'd0);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] exp_val);
        issue(rd, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, op, addr, 32'h0, '{rd: rd, data: exp_val, wen: 1'b1});
    endtask

    task automatic store(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] sdata);
        wa.delete(); wd.delete();
        issue(rd, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, op, addr, sdata, '{rd: rd, data: 32'h0, wen: 1'b0});
    endtask

    initial begin
        int cnt;
        int found;
        clear_inputs();
        rst_in            = 1'b1;
        grant_en          = 1'b1;
        io_buffer_full_in = 1'b0;
        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
        ram[32'h200] = 8'h80;
        ram[32'h210] = 8'h01; ram[32'h211] = 8'h80;

        repeat (2) @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        check("rst_rd",    32'(rsd_addr_out),         32'd0);
        check("rst_data",  rsd_data_out,              32'd0);
        check("rst_en",    32'(write_rsd_or_not_out), 32'd0);
        check("rst_stall", 32'(stall_req_out),        32'd0);
        check("rst_req",   32'(mem_bus.mem_req_out),  32'd0);
        check("rst_wr",    32'(mem_bus.mem_wr_out),   32'd0);
        check("rst_a",     mem_bus.mem_a_out,         32'd0);

        // Pass-through of a non-memory instruction.
        issue(5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, '{rd: 5'd5, data: 32'h1234, wen: 1'b1});
        check("alu_trace_len", 32'(tr_stall.size()), 32'd1);
        check("alu_stall",     32'(tr_stall[0]),      32'd0);

        // LW with grant held high.
        load(3'b010, 32'h100, 5'd7, 32'h1234_5678);
        check("lw_trace_len", 32'(tr_stall.size()), 32'd7);
        if (tr_stall.size() == 7) begin
            cnt = 0;
            foreach (tr_stall[i]) cnt += int'(tr_stall[i]);
            check("lw_stall_cycles", 32'(cnt), 32'd6);
            check("lw_stall_last",   32'(tr_stall[6]), 32'd0);
            check("lw_req_wg",       32'(tr_req[1]),   32'd1);
            for (int i = 0; i < 4; i++) check("lw_addr", tr_a[2+i], 32'h100 + 32'(i));
            check("lw_addr_last",    tr_a[6],          32'd0);
        end

        load(3'b000, 32'h200, 5'd8,  32'hFFFF_FF80);
        load(3'b100, 32'h200, 5'd9,  32'h0000_0080);
        load(3'b001, 32'h210, 5'd10, 32'hFFFF_8001);
        load(3'b101, 32'h210, 5'd11, 32'h0000_8001);

        // SH: two write cycles, low byte first.
        store(3'b001, 32'h300, 5'd12, 32'hAABB_CCDD);
        cnt = 0;
        foreach (tr_wr[i]) cnt += int'(tr_wr[i]);
        check("sh_wr_cycles", 32'(cnt), 32'd2);
        check("sh_nwrites",   32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("sh_a0", wa[0], 32'h300); check("sh_d0", 32'(wd[0]), 32'hDD);
            check("sh_a1", wa[1], 32'h301); check("sh_d1", 32'(wd[1]), 32'hCC);
        end

        // SW across the top of the address space.
        store(3'b010, 32'hFFFF_FFFE, 5'd13, 32'h1122_3344);
        check("sw_nwrites", 32'(wa.size()), 32'd4);
        if (wa.size() == 4) begin
            check("sw_a2", wa[2], 32'h0); check("sw_a3", wa[3], 32'h1);
            check("sw_d0", 32'(wd[0]), 32'h44); check("sw_d3", 32'(wd[3]), 32'h11);
        end

        // LW with grant withheld for several cycles.
        grant_en = 1'b0;
        fork
            load(3'b010, 32'h100, 5'd14, 32'h1234_5678);
            begin repeat (5) @(posedge clk); #1 grant_en = 1'b1; end
        join
        check("gw_trace_len", 32'(tr_stall.size()), 32'd10);
        if (tr_stall.size() == 10) begin
            for (int i = 1; i < 5; i++) begin
                check("gw_req",   32'(tr_req[i]),   32'd1);
                check("gw_a",     tr_a[i],          32'd0);
                check("gw_stall", 32'(tr_stall[i]), 32'd1);
            end
            check("gw_first_addr", tr_a[5], 32'h100);
        end

        // Read and write together behave as a load.
        wa.delete(); wd.delete();
        issue(5'd15, 32'h0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h100, 32'hFFFF_FFFF,
              '{rd: 5'd15, data: 32'h1234_5678, wen: 1'b1});
        check("rw_no_write", 32'(wa.size()), 32'd0);

`ifdef IO_FULL_STALL_EN
        io_buffer_full_in = 1'b1;
        wa.delete(); wd.delete();
        fork
            issue(5'd16, 32'h0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0003_0000, 32'h5A,
                  '{rd: 5'd16, data: 32'h0, wen: 1'b0});
            begin repeat (6) @(posedge clk); #1 io_buffer_full_in = 1'b0; end
        join
        if (tr_req.size() >= 5)
            for (int i = 1; i < 5; i++) begin
                check("io_hold_req", 32'(tr_req[i]), 32'd0);
                check("io_hold_wr",  32'(tr_wr[i]),  32'd0);
            end
        check("io_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) check("io_data", 32'(wd[0]), 32'h5A);
`else
        io_buffer_full_in = 1'b1;
        wa.delete(); wd.delete();
        issue(5'd16, 32'h0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0003_0000, 32'h5A,
              '{rd: 5'd16, data: 32'h0, wen: 1'b0});
        io_buffer_full_in = 1'b0;
        check("io_trace_len", 32'(tr_stall.size()), 32'd3);
        check("io_nwrites",   32'(wa.size()),       32'd1);
        if (wa.size() == 1) check("io_data", 32'(wd[0]), 32'h5A);
`endif

        // Leave nonzero writeback state, then abort a SW mid-flight with reset.
        load(3'b010, 32'h100, 5'd17, 32'h1234_5678);
        wa.delete(); wd.delete();
        @(posedge clk); #1;
        mem_write_or_not_in = 1'b1; mem_op_in = 3'b010;
        mem_addr_in = 32'h500; store_data_in = 32'hCAFE_F00D; rsd_addr_in = 5'd18;
        cnt = 0;
        do begin @(negedge clk); cnt++; end
        while (!(mem_bus.mem_wr_out && mem_bus.mem_a_out == 32'h502) && cnt < 40);
        check("rst_reach_byte2", 32'(mem_bus.mem_a_out), 32'h502);
        rst_in = 1'b1;
        clear_inputs();
        @(posedge clk); #1 rst_in = 1'b0;
        @(negedge clk);
        check("abort_req",   32'(mem_bus.mem_req_out),  32'd0);
        check("abort_wr",    32'(mem_bus.mem_wr_out),   32'd0);
        check("abort_a",     mem_bus.mem_a_out,         32'd0);
        check("abort_stall", 32'(stall_req_out),        32'd0);
        check("abort_rd",    32'(rsd_addr_out),         32'd0);
        check("abort_data",  rsd_data_out,              32'd0);
        check("abort_en",    32'(write_rsd_or_not_out), 32'd0);
        repeat (4) @(negedge clk);
        found = 0;
        foreach (wa[i]) if (wa[i] == 32'h503) found++;
        check("abort_no_byte3", 32'(found), 32'd0);

        load(3'b010, 32'h100, 5'd19, 32'h1234_5678);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the RV32I pipeline. It sits between the EX/MEM latch and the MEM/WB latch. It takes the latched EX result and performs byte-serial loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over the 8-bit RAM port, which is arbitrated with IF via a req/grant pair. It stalls the pipeline while an access is in flight and delivers the registered writeback triple to MEM/WB.

Parameters:
ADDR_WIDTH, 32, width of data address and RAM address bus.
IO_ADDR_BASE, 32'h00030000, lowest address of the memory-mapped IO region (used only by the optional feature).

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
rsd_addr_in  input  5  destination register from EX/MEM
rsd_data_in  input  32  ALU result from EX/MEM, passed through for non-loads
write_rsd_or_not_in  input  1  destination write enable from EX/MEM
mem_addr_in  input  ADDR_WIDTH  effective data address
mem_read_or_not_in  input  1  instruction is a load
mem_write_or_not_in  input  1  instruction is a store
mem_op_in  input  3  funct3 of the load/store
store_data_in  input  32  rs2 value for stores
mem_grant_in  input  1  arbiter grants RAM port to this stage
mem_din_in  input  8  RAM read byte; valid the cycle after its address
io_buffer_full_in  input  1  UART buffer full (optional feature only)
mem_req_out  output  1  requests the RAM port
mem_a_out  output  ADDR_WIDTH  RAM byte address
mem_dout_out  output  8  RAM write byte
mem_wr_out  output  1  1 = write, 0 = read
stall_req_out  output  1  to pipeline control; holds IF..EX/MEM
rsd_addr_out  output  5  to MEM/WB
rsd_data_out  output  32  to MEM/WB
write_rsd_or_not_out  output  1  to MEM/WB

Behaviour:
- Reset: every output is 0, state is IDLE, byte counter is 0. Reset mid-access aborts the access at once. From the next cycle, mem_req_out, mem_wr_out and mem_a_out are 0 and no further bytes are written.
- States: IDLE, WAIT_GRANT, ACCESS, WAIT_LAST.
- IDLE, no mem op: on the next edge, the rsd_* inputs and write_rsd_or_not_in are copied to the outputs (1-cycle latency). stall_req_out is 0.
- IDLE, mem op present (read or write asserted): stall_req_out is 1 combinationally. At the edge, the stage latches addr, op, store data and rsd_addr, goes to WAIT_GRANT, and loads write_rsd_or_not_out=0 (bubble).
- Byte count N: funct3 000/100 gives N=1; 001/101 gives N=2; any other code gives N=4.
- WAIT_GRANT: mem_req_out=1. When mem_grant_in=1 at the edge, go to ACCESS with k=0; otherwise stay.
- ACCESS with counter k: mem_req_out=1, mem_a_out=addr+k (wraps modulo 2^ADDR_WIDTH).
  - Store: mem_wr_out=1, mem_dout_out=store_data[8k+7:8k] (little-endian).
  - Load: mem_wr_out=0. Byte k is captured from mem_din_in at the edge ending cycle k+1.
  - k increments each cycle. At k=N-1, a store finishes at that edge and a load goes to WAIT_LAST.
- WAIT_LAST (loads only): mem_req_out=1, mem_a_out=0, mem_wr_out=0. The last byte is captured at this edge.
- Load result: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Outside ACCESS, mem_a_out, mem_dout_out and mem_wr_out are 0. The grant is held by the arbiter while mem_req_out=1; mem_grant_in is ignored outside WAIT_GRANT.
- Finishing edge: this is the store's last ACCESS cycle or the load's WAIT_LAST cycle.
  - stall_req_out is 0 during that cycle.
  - The outputs are loaded with the latched rsd_addr; rsd_data_out is the load value (load) or 0 (store); write_rsd_or_not_out is the latched enable (load) or 0 (store).
  - The state returns to IDLE.
- stall_req_out is 1 in all other non-IDLE cycles.
- Inputs presented while not IDLE are ignored; upstream holds them via stall.
- read and write asserted together: treated as a load.
- Load latency after grant is N+1 cycles; store latency is N cycles.

Optional Feature:
IO_FULL_STALL_EN
- Defined: a store with mem_addr >= IO_ADDR_BASE stays in WAIT_GRANT, and mem_req_out stays 0, while io_buffer_full_in=1. It proceeds normally once the input drops.
- Undefined: io_buffer_full_in is ignored and IO stores behave like RAM stores.

Test Plan:
- Non-mem op, rsd_addr 5, data 32'h1234, enable 1 -> outputs 5/32'h1234/1 after one edge; stall_req_out 0 throughout.
- LW at 0x100, RAM 78,56,34,12, grant held high -> mem_a_out 0x100..0x103 on consecutive cycles; stall high for 6 cycles (IDLE-accept, WAIT_GRANT, 4×ACCESS) and low in WAIT_LAST; rsd_data_out 32'h12345678 with enable 1.
- Sign handling: LB of byte 8'h80 gives 32'hFFFFFF80; LBU gives 32'h00000080; LH of bytes 01,80 gives 32'hFFFF8001; LHU gives 32'h00008001.
- SH store_data 32'hAABBCCDD at 0x300 -> mem_wr_out=1 for 2 cycles writing DD@0x300 and CC@0x301; write_rsd_or_not_out 0; SW at 32'hFFFFFFFE wraps the address to 0x0 and 0x1.
- grant withheld 3 cycles during LW -> mem_req_out 1, mem_a_out 0, stall 1 throughout; the access starts the cycle after grant rises; result is unchanged.
- rst_in pulsed during SW byte 2 -> the following cycle has mem_wr_out 0, mem_req_out 0, all outputs 0, IDLE; bytes 3.. are never written. With IO_FULL_STALL_EN: SB to 0x30000 with full=1 for 4 cycles -> no write until full drops.
